// File: rtl/user_project_io_bridge.sv
// User/fabric pin bridge: UIN synchroniser, FIN register, isolation FSM.
// Optional macro USER_IO_LOOPBACK_EN adds a FIN->FOUT loopback mode.
module user_project_io_bridge #(
    parameter int NUM_CH         = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int QUIESCE_CYCLES = 4,
    parameter logic [NUM_CH-1:0] UOUT_ISO_VAL = {NUM_CH{1'b0}},
    parameter logic [NUM_CH-1:0] FOUT_ISO_VAL = {NUM_CH{1'b0}}
) (
    input  logic              UserCLK,
    input  logic              rst,
`ifdef USER_IO_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic [NUM_CH-1:0] UIN,
    output logic [NUM_CH-1:0] UOUT,
    input  logic [NUM_CH-1:0] FIN,
    output logic [NUM_CH-1:0] FOUT,
    input  logic              iso_req,
    output logic              iso_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        RUN,
        QUIESCE,
        ISOLATED,
        WARMUP
    } state_e;

    localparam logic [7:0] QC_LOAD = 8'(QUIESCE_CYCLES - 1);
    localparam logic [7:0] SS_RST  = 8'(SYNC_STAGES);
    localparam logic [7:0] SS_LOAD = 8'(SYNC_STAGES - 1);
    localparam int         SLAST   = SYNC_STAGES - 2;

    // fout_q acts as the final synchroniser stage when live
    logic [NUM_CH-1:0] sync_q [SYNC_STAGES-1];

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] uout_q, uout_d;
    logic [NUM_CH-1:0] fout_q, fout_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic [NUM_CH-1:0] live_f, live_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (iso_req) begin
                    state_d = QUIESCE;
                    cnt_d   = QC_LOAD;
                end
            end
            QUIESCE: begin
                if (cnt_q == 8'd0) state_d = ISOLATED;
                else cnt_d = cnt_q - 8'd1;
            end
            ISOLATED: begin
                if (!iso_req) begin
                    state_d = WARMUP;
                    cnt_d   = SS_LOAD;
                end
            end
            WARMUP: begin
                if (iso_req) state_d = ISOLATED;
                else if (cnt_q == 8'd0) state_d = RUN;
                else cnt_d = cnt_q - 8'd1;
            end
            default: begin
                state_d = WARMUP;
                cnt_d   = SS_LOAD;
            end
        endcase
    end

    always_comb begin
        live_f = sync_q[SLAST];
        live_u = FIN;
`ifdef USER_IO_LOOPBACK_EN
        if (loopback) begin
            live_f = FIN;
            live_u = UOUT_ISO_VAL;
        end
`endif
    end

    // Outputs decode from the next state so every pin is a plain flop
    always_comb begin
        uout_d = UOUT_ISO_VAL;
        fout_d = FOUT_ISO_VAL;
        unique case (state_d)
            RUN: begin
                uout_d = live_u;
                fout_d = live_f;
            end
            QUIESCE: begin
                uout_d = uout_q;
                fout_d = fout_q;
            end
            default: begin
                uout_d = UOUT_ISO_VAL;
                fout_d = FOUT_ISO_VAL;
            end
        endcase
        ack_d  = (state_d == ISOLATED);
        busy_d = (state_d == QUIESCE) || (state_d == WARMUP);
    end

    always_ff @(posedge UserCLK) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES - 1; i++) sync_q[i] <= '0;
            state_q <= WARMUP;
            cnt_q   <= SS_RST;
            uout_q  <= UOUT_ISO_VAL;
            fout_q  <= FOUT_ISO_VAL;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            sync_q[0] <= UIN;
            for (int i = 1; i < SYNC_STAGES - 1; i++) sync_q[i] <= sync_q[i-1];
            state_q <= state_d;
            cnt_q   <= cnt_d;
            uout_q  <= uout_d;
            fout_q  <= fout_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign UOUT    = uout_q;
    assign FOUT    = fout_q;
    assign iso_ack = ack_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_user_project_io_bridge.sv
// Bench for user_project_io_bridge: directed table, corner sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_user_project_io_bridge;

    localparam int NCH = 20;
    localparam int SS  = 2;
    localparam int QC  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           iso = 1'b0;
    logic           lb  = 1'b0;
    logic [NCH-1:0] uin = '0;
    logic [NCH-1:0] fin = '0;
    logic [NCH-1:0] uout, fout;
    logic           ack, bsy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    user_project_io_bridge #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .QUIESCE_CYCLES(QC),
        .UOUT_ISO_VAL('0), .FOUT_ISO_VAL('0)
    ) dut (
        .UserCLK(clk),
        .rst(rst),
`ifdef USER_IO_LOOPBACK_EN
        .loopback(lb),
`endif
        .UIN(uin),
        .UOUT(uout),
        .FIN(fin),
        .FOUT(fout),
        .iso_req(iso),
        .iso_ack(ack),
        .busy(bsy)
    );

    // Reference model: modes with absolute-edge deadlines plus UIN history
    typedef enum {M_RUN, M_QUI, M_ISO, M_WARM} mode_e;
    mode_e          m_mode = M_WARM;
    int             k      = 0;
    int             dl     = 0;
    logic [NCH-1:0] hist[$];
    logic [NCH-1:0] m_f = '0, m_u = '0;
    logic           m_ack = 1'b0, m_busy = 1'b1;

    task automatic chk(input string nm, input logic [NCH-1:0] got,
                       input logic [NCH-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %h expected %h", nm, k, got, exp);
    endtask

    task automatic clamp(input logic a, input logic b);
        m_f = '0;
        m_u = '0;
        m_ack = a;
        m_busy = b;
    endtask

    task automatic model_edge();
        logic [NCH-1:0] lf, lu;
        k++;
        lf = hist[SS-2];
        lu = fin;
        if (lb) begin
            lf = fin;
            lu = '0;
        end
        if (rst) begin
            m_mode = M_WARM;
            dl = k + SS + 1;
            clamp(1'b0, 1'b1);
        end else begin
            case (m_mode)
                M_RUN: begin
                    if (iso) begin
                        m_mode = M_QUI;
                        dl = k + QC;
                        m_busy = 1'b1;
                    end else begin
                        m_f = lf;
                        m_u = lu;
                        m_busy = 1'b0;
                    end
                    m_ack = 1'b0;
                end
                M_QUI: begin
                    if (k == dl) begin
                        m_mode = M_ISO;
                        clamp(1'b1, 1'b0);
                    end
                end
                M_ISO: begin
                    if (!iso) begin
                        m_mode = M_WARM;
                        dl = k + SS;
                        clamp(1'b0, 1'b1);
                    end else clamp(1'b1, 1'b0);
                end
                default: begin
                    if (iso) begin
                        m_mode = M_ISO;
                        clamp(1'b1, 1'b0);
                    end else if (k == dl) begin
                        m_mode = M_RUN;
                        m_f = lf;
                        m_u = lu;
                        m_ack = 1'b0;
                        m_busy = 1'b0;
                    end else clamp(1'b0, 1'b1);
                end
            endcase
        end
        hist.push_front(rst ? '0 : uin);
        void'(hist.pop_back());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("m_fout", fout, m_f);
        chk("m_uout", uout, m_u);
        chk("m_ack", {19'd0, ack}, {19'd0, m_ack});
        chk("m_busy", {19'd0, bsy}, {19'd0, m_busy});
    endtask

    typedef struct {
        logic           r;
        logic           i;
        logic [NCH-1:0] u;
        logic [NCH-1:0] f;
        logic [NCH-1:0] ef;
        logic [NCH-1:0] eu;
        logic           ea;
        logic           eb;
    } vec_t;

    vec_t vt[22];

    initial begin
        for (int i = 0; i < SS - 1; i++) hist.push_back('0);

        // reset release, latency, isolate and recover
        for (int i = 0; i < 3; i++)
            vt[i] = '{1'b1, 1'b0, 20'hABCDE, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 20'hABCDE, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 20'hABCDE, 20'h0, 20'h0, 20'h0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 20'hABCDE, 20'h0, 20'hABCDE, 20'h0, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 20'hABCDE, 20'h12345, 20'hABCDE, 20'h12345,
                   1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 20'h55555, 20'h12345, 20'hABCDE, 20'h12345,
                   1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 20'h55555, 20'h12345, 20'h55555, 20'h12345,
                   1'b0, 1'b0};
        for (int i = 9; i < 13; i++)
            vt[i] = '{1'b0, 1'b1, 20'h11111, 20'h22222, 20'h55555, 20'h12345,
                      1'b0, 1'b1};
        for (int i = 13; i < 19; i++)
            vt[i] = '{1'b0, 1'b1, 20'h11111, 20'h22222, 20'h0, 20'h0, 1'b1, 1'b0};
        vt[19] = '{1'b0, 1'b0, 20'h11111, 20'h22222, 20'h0, 20'h0, 1'b0, 1'b1};
        vt[20] = '{1'b0, 1'b0, 20'h11111, 20'h22222, 20'h0, 20'h0, 1'b0, 1'b1};
        vt[21] = '{1'b0, 1'b0, 20'h11111, 20'h22222, 20'h11111, 20'h22222,
                   1'b0, 1'b0};

        for (int i = 0; i < 22; i++) begin
            rst = vt[i].r;
            iso = vt[i].i;
            uin = vt[i].u;
            fin = vt[i].f;
            step();
            chk($sformatf("t%0d_fout", i), fout, vt[i].ef);
            chk($sformatf("t%0d_uout", i), uout, vt[i].eu);
            chk($sformatf("t%0d_ack", i), {19'd0, ack}, {19'd0, vt[i].ea});
            chk($sformatf("t%0d_busy", i), {19'd0, bsy}, {19'd0, vt[i].eb});
        end

        // request dropped during quiesce still isolates
        for (int i = 0; i < 3; i++) step();
        iso = 1'b1;
        step();
        chk("quiesce_busy", {19'd0, bsy}, 20'd1);
        iso = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("quiesce_noack", {19'd0, ack}, 20'd0);
        end
        step();
        chk("drop_mid_quiesce_ack", {19'd0, ack}, 20'd1);
        step();
        chk("warmup_entered", {19'd0, bsy}, 20'd1);

        // re-request during warmup isolates without quiesce
        iso = 1'b1;
        step();
        chk("warmup_reassert_ack", {19'd0, ack}, 20'd1);
        chk("warmup_reassert_busy", {19'd0, bsy}, 20'd0);

        // reset while quiescing
        iso = 1'b0;
        for (int i = 0; i < 4; i++) step();
        iso = 1'b1;
        step();
        iso = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_quiesce_busy", {19'd0, bsy}, 20'd1);
        chk("rst_quiesce_ack", {19'd0, ack}, 20'd0);
        chk("rst_quiesce_fout", fout, 20'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();

`ifdef USER_IO_LOOPBACK_EN
        lb = 1'b1;
        fin = 20'h0F0F0;
        uin = 20'h33333;
        step();
        chk("lb_fout", fout, 20'h0F0F0);
        chk("lb_uout", uout, 20'h0);
        iso = 1'b1;
        for (int i = 0; i < QC + 1; i++) step();
        chk("lb_iso_fout", fout, 20'h0);
        chk("lb_iso_ack", {19'd0, ack}, 20'd1);
        iso = 1'b0;
        for (int i = 0; i < 4; i++) step();
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            uin = NCH'($urandom);
            fin = NCH'($urandom);
            if ($urandom_range(0, 9) == 0) iso = ~iso;
            rst = ($urandom_range(0, 79) == 0);
`ifdef USER_IO_LOOPBACK_EN
            if ($urandom_range(0, 15) == 0) lb = ~lb;
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
